// File: rtl/bram_model.sv
// Single-port 32-bit block RAM model with a byte-addressed port.
// After reset it zero-fills every word, one word per clock. It also flags
// accesses outside the array, so simulation never returns unknown data.
// Read-first behaviour: a write returns the pre-write word on the same cycle.

module bram_model #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              init_done,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-3:0] DEPTH_WORDS = (ADDR_W-2)'(DEPTH);
  localparam logic [CNT_W-1:0]  SWEEP_END   = CNT_W'(DEPTH);

  // Power-on contents never reach douta: reads are blocked until the sweep
  // has written every word, so the array needs no initial value of its own.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  sweep_cnt;
  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic [IDX_W-1:0]  sweep_idx;
  logic              in_range;
  logic              sweep_busy;
  logic              unused_addr_bits;

  // The low two address bits select a byte within a word. They are ignored,
  // so unaligned addresses alias to the word that contains them.
  assign word_idx         = addra[ADDR_W-1:2];
  assign unused_addr_bits = ^addra[1:0];

  // Full-width compare: indices at or above DEPTH are errors. They do not
  // wrap into the array.
  assign in_range   = (word_idx < DEPTH_WORDS);
  assign mem_idx    = word_idx[IDX_W-1:0];
  assign sweep_idx  = sweep_cnt[IDX_W-1:0];
  assign sweep_busy = (sweep_cnt != SWEEP_END);

  // Storage: the sweep writes zeros until init_done. After that, only
  // enabled, in-range writes change the array.
  always_ff @(posedge clka) begin
    if (!init_done) begin
      if (rsta_n && sweep_busy) begin
        mem[sweep_idx] <= '0;
      end
    end else if (ena && wea && in_range) begin
      mem[mem_idx] <= dina;
    end
  end

  // Sweep sequencing, registered read-first output and the sticky range error.
  // init_done rises on the edge after the last zero write.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      sweep_cnt <= '0;
      init_done <= 1'b0;
      douta     <= '0;
      addr_err  <= 1'b0;
    end else if (!init_done) begin
      if (sweep_busy) begin
        sweep_cnt <= sweep_cnt + 1'b1;
      end else begin
        init_done <= 1'b1;
      end
    end else if (ena) begin
      if (in_range) begin
        douta <= mem[mem_idx];
      end else begin
        douta    <= '0;
        addr_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bram_model.sv
// Randomised scoreboard bench for bram_model. The stimulus tasks predict each
// cycle's douta/addr_err from a plain array model and queue the prediction.
// A monitor pops one prediction per clock, shortly after the edge.

module tb_bram_model;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rsta_n;
  logic        ena;
  logic        wea;
  logic [31:0] addra;
  logic [31:0] dina;
  logic [31:0] douta;
  logic        init_done;
  logic        addr_err;

  typedef struct {
    logic [31:0] dout;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_dout;
  logic        ref_err;
  int          pass_cnt;
  int          total_cnt;

  bram_model #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clka      (clk),
    .rsta_n    (rsta_n),
    .ena       (ena),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .douta     (douta),
    .init_done (init_done),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Monitor: one prediction per clock edge, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check("douta", douta, mon_e.dout);
      check("addr_err", {31'b0, addr_err}, {31'b0, mon_e.err});
    end
  end

  // Reference model: the result follows from the memory rules, not from any RTL structure.
  task automatic cyc(input bit en, input bit we, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   idx;
    @(negedge clk);
    ena   = en;
    wea   = we;
    addra = addr;
    dina  = data;
    if (en) begin
      idx = int'(addr >> 2);
      if (addr < 32'(DEPTH * 4)) begin
        ref_dout = ref_mem[idx];
        if (we) ref_mem[idx] = data;
      end else begin
        ref_dout = 32'h0;
        ref_err  = 1'b1;
      end
    end
    e.dout = ref_dout;
    e.err  = ref_err;
    sb.push_back(e);
  endtask

  task automatic drain();
    cyc(0, 0, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic garbage_inputs();
    ena   = 1'($urandom);
    wea   = 1'b1;
    addra = $urandom_range(0, DEPTH - 1) << 2;
    dina  = $urandom | 32'h1;
  endtask

  // Release reset while busy inputs are applied. Expect init_done exactly DEPTH+1 edges later.
  task automatic release_and_sweep();
    @(negedge clk);
    rsta_n = 1'b1;
    repeat (DEPTH) begin
      @(negedge clk);
      garbage_inputs();
    end
    check("init_done_early", {31'b0, init_done}, 32'd0);
    check("douta_during_sweep", douta, 32'h0);
    @(posedge clk);
    #1;
    check("init_done_set", {31'b0, init_done}, 32'd1);
    check("douta_after_sweep", douta, 32'h0);
    check("addr_err_after_sweep", {31'b0, addr_err}, 32'd0);
    ena = 1'b0;
    wea = 1'b0;
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    ref_dout = 32'h0;
    ref_err  = 1'b0;
  endtask

  task automatic assert_reset_checked(input string tag);
    @(negedge clk);
    rsta_n = 1'b0;
    ena    = 1'b0;
    #1;
    check({tag, "_douta"}, douta, 32'h0);
    check({tag, "_init_done"}, {31'b0, init_done}, 32'd0);
    check({tag, "_addr_err"}, {31'b0, addr_err}, 32'd0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rsta_n    = 1'b0;
    ena       = 1'b0;
    wea       = 1'b0;
    addra     = 32'h0;
    dina      = 32'h0;
    ref_dout  = 32'h0;
    ref_err   = 1'b0;
    #12;
    check("rst_douta", douta, 32'h0);
    check("rst_init_done", {31'b0, init_done}, 32'd0);
    check("rst_addr_err", {31'b0, addr_err}, 32'd0);
    release_and_sweep();

    // Plain read, then write followed by a read and an idle hold.
    cyc(1, 0, 32'h4, 32'h0);
    cyc(1, 1, 32'h4, 32'h1);
    cyc(1, 0, 32'h4, 32'h0);
    repeat (3) cyc(0, 0, 32'h4, 32'hFFFF);

    // Read-modify-write using the addr, idle, consume pattern.
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 32'h4, 32'h0);
      cyc(0, 0, 32'h4, 32'h0);
      cyc(1, 1, 32'h4, douta + 32'h1);
    end
    cyc(1, 0, 32'h4, 32'h0);
    cyc(0, 0, 32'h0, 32'h0);
    check("rmw_final", douta, 32'd6);

    // Same-cycle write returns the old word; the next read returns the new one.
    cyc(1, 1, 32'h8, 32'h11);
    cyc(1, 1, 32'h8, 32'hA5);
    cyc(1, 0, 32'h8, 32'h0);

    // Out-of-range access: write suppressed, error sticky, word 0 untouched.
    cyc(1, 1, 32'h1000, 32'h7);
    cyc(1, 0, 32'h0, 32'h0);
    cyc(1, 0, 32'hFFC, 32'h0);
    repeat (2) cyc(0, 0, 32'h0, 32'h0);

    // Unaligned address aliases to the containing word.
    cyc(1, 1, 32'hE, 32'hCAFE_0003);
    cyc(1, 0, 32'hC, 32'h0);
    cyc(1, 0, 32'hD, 32'h0);

    // Random traffic: mostly low words, sometimes near or past the top.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(DEPTH - 4, DEPTH + 4) << 2) | $urandom_range(0, 3);
      else                           a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), a, $urandom);
    end
    drain();

    // Reset part-way through the sweep, then let the sweep run to completion.
    assert_reset_checked("pre_sweep_rst");
    @(negedge clk);
    rsta_n = 1'b1;
    repeat (300) @(negedge clk);
    assert_reset_checked("mid_sweep_rst");
    release_and_sweep();

    // Reset during normal operation with non-zero douta; word 0x4 must read back 0 afterwards.
    cyc(1, 1, 32'h4, 32'h55);
    cyc(1, 0, 32'h4, 32'h0);
    drain();
    check("pre_rst_douta", douta, 32'h55);
    assert_reset_checked("mid_op_rst");
    release_and_sweep();
    cyc(1, 0, 32'h4, 32'h0);
    cyc(1, 0, 32'h8, 32'h0);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
